// File: rtl/draw_pkg.sv
// Shared definitions for the sprite drawing datapath.
//   SCREEN_W / SCREEN_H : VGA adapter resolution in pixels
//   X_W / Y_W / COL_W   : coordinate and colour widths of the adapter interface
//   BG_COLOUR           : colour written when erasing
//   dir_t               : one-bit movement direction per axis
package draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;

  localparam logic [COL_W-1:0] BG_COLOUR = 3'b000;

  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_t;

endpackage

// File: rtl/box_scan_counter.sv
// Raster scan over a W x H box, x fastest. Shared by the draw and erase passes.
//   clock, reset : clock, async active-high reset
//   en           : advance one pixel per edge; when low the scan returns to (0,0)
//   ox, oy       : current offset inside the box
//   last         : offset is the bottom-right pixel
module box_scan_counter #(
  parameter  int W    = 4,
  parameter  int H    = 4,
  localparam int OX_W = (W > 1) ? $clog2(W) : 1,
  localparam int OY_W = (H > 1) ? $clog2(H) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            en,
  output logic [OX_W-1:0] ox,
  output logic [OY_W-1:0] oy,
  output logic            last
);

  localparam logic [OX_W-1:0] OX_LAST = OX_W'(W - 1);
  localparam logic [OY_W-1:0] OY_LAST = OY_W'(H - 1);

  logic ox_at_end;
  logic oy_at_end;

  assign ox_at_end = (ox == OX_LAST);
  assign oy_at_end = (oy == OY_LAST);
  assign last      = ox_at_end && oy_at_end;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ox <= '0;
      oy <= '0;
    end else if (!en) begin
      ox <= '0;
      oy <= '0;
    end else if (ox_at_end) begin
      ox <= '0;
      oy <= oy_at_end ? '0 : oy + 1'b1;
    end else begin
      ox <= ox + 1'b1;
    end
  end

endmodule

// File: rtl/sprite_draw_datapath.sv
// Datapath for the bouncing-sprite animation. Executes load / draw / erase /
// delay commands from the control FSM and drives the VGA adapter pixel port.
//   clock, reset            : clock, async active-high reset
//   x_in, y_in, colour_in   : initial position and sprite colour
//   ld_x_out, ld_y_out      : load (clamped) base position, direction reset to +1
//   plot, sel_col           : pixel write request, 1 selects the erase colour
//   enable_posCounter_W/_B  : scan the sprite box for draw / erase
//   enable_delayCounter     : run the frame-hold counter
//   x_out, y_out, colour_out, writeEn : adapter pixel port
//   doneW, doneB, waited    : status strobes back to the FSM
//
// Pixel port handshake: writeEn acts as a valid with no ready; the adapter
// accepts x_out/y_out/colour_out on every clock edge where writeEn is high.
module sprite_draw_datapath
  import draw_pkg::*;
#(
  parameter int               SPRITE_W  = 4,
  parameter int               SPRITE_H  = 4,
  parameter int               DELAY     = 833333,
  parameter int               SCREEN_W  = draw_pkg::SCREEN_W,
  parameter int               SCREEN_H  = draw_pkg::SCREEN_H,
  parameter logic [COL_W-1:0] BG_COLOUR = draw_pkg::BG_COLOUR
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [X_W-1:0]   x_in,
  input  logic [Y_W-1:0]   y_in,
  input  logic [COL_W-1:0] colour_in,
  input  logic             ld_x_out,
  input  logic             ld_y_out,
  input  logic             plot,
  input  logic             sel_col,
  input  logic             enable_posCounter_W,
  input  logic             enable_posCounter_B,
  input  logic             enable_delayCounter,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic [COL_W-1:0] colour_out,
  output logic             writeEn,
  output logic             doneW,
  output logic             doneB,
  output logic             waited
);

  localparam int OX_W  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int OY_W  = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int DLY_W = $clog2(DELAY + 1);

  // Largest base position that keeps the whole sprite on screen.
  localparam logic [X_W-1:0]   X_MAX    = X_W'(SCREEN_W - SPRITE_W);
  localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(SCREEN_H - SPRITE_H);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY - 1);

  logic [X_W-1:0]   base_x, nx_x;
  logic [Y_W-1:0]   base_y, nx_y;
  dir_t             dx, nx_dx;
  dir_t             dy, nx_dy;
  logic [OX_W-1:0]  ox;
  logic [OY_W-1:0]  oy;
  logic             last;
  logic             scan_en;
  logic [DLY_W-1:0] dly_cnt;

  // One counter serves both passes; the FSM never legally runs both at once.
  assign scan_en = enable_posCounter_W | enable_posCounter_B;

  box_scan_counter #(
    .W (SPRITE_W),
    .H (SPRITE_H)
  ) u_scan (
    .clock (clock),
    .reset (reset),
    .en    (scan_en),
    .ox    (ox),
    .oy    (oy),
    .last  (last)
  );

  assign doneW      = enable_posCounter_W & last;
  assign doneB      = enable_posCounter_B & last & ~enable_posCounter_W;
  assign x_out      = base_x + X_W'(ox);
  assign y_out      = base_y + Y_W'(oy);
  assign colour_out = sel_col ? BG_COLOUR : colour_in;
  assign writeEn    = plot;
  assign waited     = enable_delayCounter & (dly_cnt == DLY_LAST);

  // Next diagonal step with edge bounce. An axis with no room to move holds.
  always_comb begin
    nx_x  = base_x;
    nx_dx = dx;
    if (X_MAX != '0) begin
      if (dx == DIR_POS) begin
        if (base_x == X_MAX) begin
          nx_dx = DIR_NEG;
          nx_x  = base_x - 1'b1;
        end else begin
          nx_x  = base_x + 1'b1;
        end
      end else begin
        if (base_x == '0) begin
          nx_dx = DIR_POS;
          nx_x  = base_x + 1'b1;
        end else begin
          nx_x  = base_x - 1'b1;
        end
      end
    end
  end

  always_comb begin
    nx_y  = base_y;
    nx_dy = dy;
    if (Y_MAX != '0) begin
      if (dy == DIR_POS) begin
        if (base_y == Y_MAX) begin
          nx_dy = DIR_NEG;
          nx_y  = base_y - 1'b1;
        end else begin
          nx_y  = base_y + 1'b1;
        end
      end else begin
        if (base_y == '0) begin
          nx_dy = DIR_POS;
          nx_y  = base_y + 1'b1;
        end else begin
          nx_y  = base_y - 1'b1;
        end
      end
    end
  end

  // Base position: a load beats a move issued in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_x <= '0;
      base_y <= '0;
      dx     <= DIR_POS;
      dy     <= DIR_POS;
    end else begin
      if (ld_x_out) begin
        base_x <= (x_in > X_MAX) ? X_MAX : x_in;
        dx     <= DIR_POS;
      end else if (doneB) begin
        base_x <= nx_x;
        dx     <= nx_dx;
      end
      if (ld_y_out) begin
        base_y <= (y_in > Y_MAX) ? Y_MAX : y_in;
        dy     <= DIR_POS;
      end else if (doneB) begin
        base_y <= nx_y;
        dy     <= nx_dy;
      end
    end
  end

  // Frame-hold counter; dropping the enable restarts the full delay.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dly_cnt <= '0;
    end else if (!enable_delayCounter || dly_cnt == DLY_LAST) begin
      dly_cnt <= '0;
    end else begin
      dly_cnt <= dly_cnt + 1'b1;
    end
  end

endmodule
